rob_commit: RTL and testbench

- Reorder buffer for the out-of-order RV32I core. Allocates one entry per dispatched instruction and captures results broadcast on the CDB.
- Retires entries strictly in program order and drives the architectural write port of the rename table / register file: regf_we, rd_wb_addr, rd_data, rd_rob_idx.
- It is the writer end of the rename table's writeback interface and supplies the ROB index the rename table records at dispatch.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/rob_ptr.sv | 34 +++
 rtl/rob_commit.sv | 130 +++++++++++++
 tb/tb_rob_commit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: ROB sizing plus the ROB entry and commit bundle layouts.
package rv32i_types;

  localparam int ROB_DEPTH     = 32;
  localparam int ROB_IDX_WIDTH = 5;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        regf_we;
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic                     regf_we;
    logic [4:0]               rd_wb_addr;
    logic [31:0]              rd_data;
    logic [ROB_IDX_WIDTH-1:0] rd_rob_idx;
  } rob_commit_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer: the MSB toggles on every lap so full and empty differ.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W:0]   ptr_o
);

  logic [W:0] ptr_q;
  logic [W:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, CDB result capture, in-order retirement to the
// architectural write port, and combinational operand lookup with CDB bypass.
module rob_commit #(
  parameter int ROB_DEPTH     = rv32i_types::ROB_DEPTH,
  parameter int ROB_IDX_WIDTH = rv32i_types::ROB_IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [4:0]               alloc_rd_addr,
  input  logic                     alloc_regf_we,
  output logic                     alloc_ready,
  output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,
  input  logic                     cdb_valid,
  input  logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx,
  input  logic [31:0]              cdb_data,
  input  logic [ROB_IDX_WIDTH-1:0] rs1_rob_idx,
  input  logic [ROB_IDX_WIDTH-1:0] rs2_rob_idx,
  output logic                     rs1_done,
  output logic                     rs2_done,
  output logic [31:0]              rs1_data,
  output logic [31:0]              rs2_data,
  input  logic                     flush,
  output logic                     regf_we,
  output logic [4:0]               rd_wb_addr,
  output logic [31:0]              rd_data,
  output logic [ROB_IDX_WIDTH-1:0] rd_rob_idx,
  output logic [ROB_IDX_WIDTH:0]   rob_count
);

  rv32i_types::rob_entry_t  entries_q [ROB_DEPTH];
  rv32i_types::rob_commit_t commit_q;

  logic [ROB_IDX_WIDTH:0]   head;
  logic [ROB_IDX_WIDTH:0]   tail;
  logic [ROB_IDX_WIDTH-1:0] head_idx;
  logic [ROB_IDX_WIDTH-1:0] tail_idx;
  logic                     full;
  logic                     alloc_fire;
  logic                     cdb_fire;
  logic                     commit_fire;

  assign head_idx = head[ROB_IDX_WIDTH-1:0];
  assign tail_idx = tail[ROB_IDX_WIDTH-1:0];
  assign full     = (head_idx == tail_idx) && (head[ROB_IDX_WIDTH] != tail[ROB_IDX_WIDTH]);

  // Full is taken from the pre-commit pointers, so a retiring slot is not reused this edge.
  assign alloc_fire  = alloc_valid && !full && !flush;
  assign cdb_fire    = cdb_valid && entries_q[cdb_rob_idx].valid && !flush;
  assign commit_fire = entries_q[head_idx].valid && entries_q[head_idx].done && !flush;

  rob_ptr #(.W(ROB_IDX_WIDTH)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (commit_fire),
    .ptr_o (head)
  );

  rob_ptr #(.W(ROB_IDX_WIDTH)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (alloc_fire),
    .ptr_o (tail)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (cdb_fire) begin
        entries_q[cdb_rob_idx].done <= 1'b1;
        entries_q[cdb_rob_idx].data <= cdb_data;
      end
      if (commit_fire) begin
        entries_q[head_idx].valid <= 1'b0;
      end
      if (alloc_fire) begin
        entries_q[tail_idx].valid   <= 1'b1;
        entries_q[tail_idx].done    <= 1'b0;
        entries_q[tail_idx].regf_we <= alloc_regf_we;
        entries_q[tail_idx].rd_addr <= alloc_rd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_q <= '0;
    end else if (commit_fire) begin
      commit_q.regf_we    <= entries_q[head_idx].regf_we && (entries_q[head_idx].rd_addr != 5'd0);
      commit_q.rd_wb_addr <= entries_q[head_idx].rd_addr;
      commit_q.rd_data    <= entries_q[head_idx].data;
      commit_q.rd_rob_idx <= head_idx;
    end else begin
      commit_q.regf_we <= 1'b0;
    end
  end

  always_comb begin
    rs1_done = entries_q[rs1_rob_idx].valid && entries_q[rs1_rob_idx].done;
    rs1_data = entries_q[rs1_rob_idx].data;
    rs2_done = entries_q[rs2_rob_idx].valid && entries_q[rs2_rob_idx].done;
    rs2_data = entries_q[rs2_rob_idx].data;
    if (cdb_valid && (cdb_rob_idx == rs1_rob_idx)) begin
      rs1_done = 1'b1;
      rs1_data = cdb_data;
    end
    if (cdb_valid && (cdb_rob_idx == rs2_rob_idx)) begin
      rs2_done = 1'b1;
      rs2_data = cdb_data;
    end
  end

  assign alloc_ready   = !full;
  assign alloc_rob_idx = tail_idx;
  assign rob_count     = tail - head;
  assign regf_we       = commit_q.regf_we;
  assign rd_wb_addr    = commit_q.rd_wb_addr;
  assign rd_data       = commit_q.rd_data;
  assign rd_rob_idx    = commit_q.rd_rob_idx;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: commit scoreboard plus directed timing/boundary checks.
module tb_rob_commit;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd_addr;
  logic        alloc_regf_we;
  logic        alloc_ready;
  logic [4:0]  alloc_rob_idx;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_idx;
  logic [31:0] cdb_data;
  logic [4:0]  rs1_rob_idx;
  logic [4:0]  rs2_rob_idx;
  logic        rs1_done;
  logic        rs2_done;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        regf_we;
  logic [4:0]  rd_wb_addr;
  logic [31:0] rd_data;
  logic [4:0]  rd_rob_idx;
  logic [5:0]  rob_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rob_commit dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_rd_addr (alloc_rd_addr),
    .alloc_regf_we (alloc_regf_we),
    .alloc_ready   (alloc_ready),
    .alloc_rob_idx (alloc_rob_idx),
    .cdb_valid     (cdb_valid),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_data      (cdb_data),
    .rs1_rob_idx   (rs1_rob_idx),
    .rs2_rob_idx   (rs2_rob_idx),
    .rs1_done      (rs1_done),
    .rs2_done      (rs2_done),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .regf_we       (regf_we),
    .rd_wb_addr    (rd_wb_addr),
    .rd_data       (rd_data),
    .rd_rob_idx    (rd_rob_idx),
    .rob_count     (rob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (regf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexp_commit", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rd", 64'(rd_wb_addr), 64'(e.rd));
        chk("sb_data", 64'(rd_data), 64'(e.data));
        chk("sb_idx", 64'(rd_rob_idx), 64'(e.idx));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] idx);
    exp_t e;
    e.rd = rd; e.data = data; e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    alloc_valid = 0; alloc_rd_addr = 0; alloc_regf_we = 0;
    cdb_valid = 0; cdb_rob_idx = 0; cdb_data = 0;
    rs1_rob_idx = 0; rs2_rob_idx = 0; flush = 0;
    #23;
    chk("rst_regf_we", 64'(regf_we), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // reset then idle
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_ready", 64'(alloc_ready), 64'd1);
      chk("idle_idx", 64'(alloc_rob_idx), 64'd0);
      chk("idle_count", 64'(rob_count), 64'd0);
      chk("idle_we", 64'(regf_we), 64'd0);
    end

    // single alloc / complete / commit latency
    alloc_valid = 1; alloc_rd_addr = 5'd5; alloc_regf_we = 1;
    chk("a0_idx", 64'(alloc_rob_idx), 64'd0);
    push(5'd5, 32'hDEADBEEF, 5'd0);
    step();
    alloc_valid = 0;
    chk("a0_count", 64'(rob_count), 64'd1);
    step();
    cdb_valid = 1; cdb_rob_idx = 5'd0; cdb_data = 32'hDEADBEEF;
    step();
    cdb_valid = 0;
    chk("a0_no_early", 64'(regf_we), 64'd0);
    step();
    chk("a0_we", 64'(regf_we), 64'd1);
    chk("a0_count_end", 64'(rob_count), 64'd0);

    // out-of-order completion, in-order retirement
    do_flush();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rd_addr = 5'(i + 1); alloc_regf_we = 1;
      chk("ooo_idx", 64'(alloc_rob_idx), 64'(i));
      push(5'(i + 1), 32'hA000_0000 + 32'(i), 5'(i));
      step();
    end
    alloc_valid = 0;
    for (int i = 2; i >= 0; i--) begin
      cdb_valid = 1; cdb_rob_idx = 5'(i); cdb_data = 32'hA000_0000 + 32'(i);
      step();
      chk("ooo_hold", 64'(regf_we), 64'd0);
    end
    cdb_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ooo_we", 64'(regf_we), 64'd1);
      chk("ooo_order", 64'(rd_rob_idx), 64'(i));
    end
    step();
    chk("ooo_idle", 64'(regf_we), 64'd0);
    chk("ooo_count", 64'(rob_count), 64'd0);

    // fill to full, then wrap
    do_flush();
    for (int i = 0; i < 32; i++) begin
      alloc_valid = 1; alloc_rd_addr = 5'((i % 31) + 1); alloc_regf_we = 1;
      chk("fill_idx", 64'(alloc_rob_idx), 64'(i));
      push(5'((i % 31) + 1), 32'h1000 + 32'(i), 5'(i));
      step();
    end
    chk("full_ready", 64'(alloc_ready), 64'd0);
    chk("full_count", 64'(rob_count), 64'd32);
    alloc_rd_addr = 5'd7;
    cdb_valid = 1; cdb_rob_idx = 5'd0; cdb_data = 32'h1000;
    step();
    cdb_valid = 0;
    chk("full_hold_ready", 64'(alloc_ready), 64'd0);
    chk("full_hold_count", 64'(rob_count), 64'd32);
    push(5'd7, 32'h7777, 5'd0);
    step();
    chk("wrap_commit_we", 64'(regf_we), 64'd1);
    chk("wrap_count31", 64'(rob_count), 64'd31);
    chk("wrap_ready", 64'(alloc_ready), 64'd1);
    chk("wrap_idx", 64'(alloc_rob_idx), 64'd0);
    step();
    alloc_valid = 0;
    chk("wrap_count32", 64'(rob_count), 64'd32);
    chk("wrap_full_again", 64'(alloc_ready), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      cdb_valid = 1; cdb_rob_idx = 5'(i % 32);
      cdb_data = (i == 32) ? 32'h7777 : 32'h1000 + 32'(i);
      step();
    end
    cdb_valid = 0;
    guard = 0;
    while (rob_count != 0 && guard < 40) begin
      step();
      guard++;
    end
    chk("drain_count", 64'(rob_count), 64'd0);

    // rd = x0 commits without a write but still retires
    alloc_valid = 1; alloc_rd_addr = 5'd0; alloc_regf_we = 1;
    chk("x0_idx", 64'(alloc_rob_idx), 64'd1);
    step();
    alloc_valid = 0;
    cdb_valid = 1; cdb_rob_idx = 5'd1; cdb_data = 32'h55;
    step();
    cdb_valid = 0;
    step();
    chk("x0_we", 64'(regf_we), 64'd0);
    chk("x0_count", 64'(rob_count), 64'd0);
    chk("x0_head_adv", 64'(alloc_rob_idx), 64'd2);

    // flush while the head completes
    do_flush();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_rd_addr = 5'(i + 10); alloc_regf_we = 1;
      step();
    end
    alloc_valid = 0;
    chk("fl_count4", 64'(rob_count), 64'd4);
    flush = 1; cdb_valid = 1; cdb_rob_idx = 5'd0; cdb_data = 32'hBAD0BAD0;
    step();
    flush = 0; cdb_valid = 0;
    chk("fl_no_commit", 64'(regf_we), 64'd0);
    chk("fl_count", 64'(rob_count), 64'd0);
    chk("fl_idx", 64'(alloc_rob_idx), 64'd0);
    chk("fl_ready", 64'(alloc_ready), 64'd1);
    step();
    chk("fl_no_late", 64'(regf_we), 64'd0);

    // operand lookup: bypass, invalid entry, stored done entry
    cdb_valid = 1; cdb_rob_idx = 5'd5; cdb_data = 32'hCAFEF00D;
    rs1_rob_idx = 5'd5; rs2_rob_idx = 5'd7;
    #1;
    chk("byp_done", 64'(rs1_done), 64'd1);
    chk("byp_data", 64'(rs1_data), 64'hCAFEF00D);
    chk("nobyp_done", 64'(rs2_done), 64'd0);
    cdb_valid = 0;
    #1;
    chk("byp_off", 64'(rs1_done), 64'd0);
    alloc_valid = 1; alloc_rd_addr = 5'd9; alloc_regf_we = 1;
    push(5'd9, 32'h1234, 5'd0);
    step();
    alloc_valid = 0;
    rs2_rob_idx = 5'd0;
    #1;
    chk("lk_pending", 64'(rs2_done), 64'd0);
    cdb_valid = 1; cdb_rob_idx = 5'd0; cdb_data = 32'h1234;
    step();
    cdb_valid = 0;
    #1;
    chk("lk_done", 64'(rs2_done), 64'd1);
    chk("lk_data", 64'(rs2_data), 64'h1234);
    step();
    chk("lk_commit", 64'(regf_we), 64'd1);
    step();

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
